// File: rtl/sm83_alu_pkg.sv
// Shared types and constants for the SM83 ALU nibble-serial adder.
package sm83_alu_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/sm83_alu_nibble_cgen.sv
// 4-bit carry lookahead for one nibble: p/g and carry-in give the carry out of each bit.
import sm83_alu_pkg::*;

module sm83_alu_nibble_cgen (
    input  logic [NIBBLE_W-1:0] p,
    input  logic [NIBBLE_W-1:0] g,
    input  logic                cin,
    output logic [NIBBLE_W:1]   c
);

    always_comb begin
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        // A masked unknown (e.g. p=0 with cin=X) must not resolve to a clean carry.
        if ((^{p, g, cin}) === 1'bx)
            c = 'x;
    end

endmodule

// File: rtl/sm83_alu_nibble_adder.sv
// Nibble-serial SM83-style adder/subtractor: one 4-bit lookahead slice reused per clock.
//
//   state | meaning
//   IDLE  | waiting for start; results and flags held
//   RUN   | processing one nibble per edge, LSB nibble first
//   DONE  | one-cycle completion, flags valid; start here chains the next op
import sm83_alu_pkg::*;

module sm83_alu_nibble_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carries,
    output logic             cout,
    output logic             hcout,
    output logic             zero
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    alu_state_t state_q, state_d;

    logic [IDX_W-1:0]    nib_idx;
    logic [WIDTH-1:0]    a_q, b_q;
    logic                sub_q;
    logic                carry_q;
    logic [WIDTH-1:0]    sum_q, carries_q;
    logic                cout_q, hcout_q, zero_q;

    logic                accept, last_nib;
    logic [WIDTH-1:0]    b_eff;
    logic [NIBBLE_W-1:0] a_nib, b_nib, p_nib, g_nib, sum_nib;
    logic [NIBBLE_W:1]   c_nib;
    logic [WIDTH-1:0]    sum_nxt, carries_nxt;

    assign accept   = start && (state_q != RUN);
    assign last_nib = (state_q == RUN) && (nib_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_nib)
                    state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign b_eff = sub_q ? ~b_q : b_q;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (nib_idx == IDX_W'(k)) begin
                a_nib = a_q[NIBBLE_W*k +: NIBBLE_W];
                b_nib = b_eff[NIBBLE_W*k +: NIBBLE_W];
            end
        end
    end

    assign p_nib = a_nib | b_nib;
    assign g_nib = a_nib & b_nib;

    sm83_alu_nibble_cgen u_cgen (
        .p   (p_nib),
        .g   (g_nib),
        .cin (carry_q),
        .c   (c_nib)
    );

    always_comb begin
        sum_nib = a_nib ^ b_nib ^ {c_nib[3:1], carry_q};
        if ((^c_nib) === 1'bx)
            sum_nib = 'x;
    end

    // Only the nibble being processed changes; the rest keep their earlier values.
    always_comb begin
        sum_nxt     = sum_q;
        carries_nxt = carries_q;
        for (int k = 0; k < NIBBLES; k++) begin
            if (nib_idx == IDX_W'(k)) begin
                sum_nxt[NIBBLE_W*k +: NIBBLE_W]     = sum_nib;
                carries_nxt[NIBBLE_W*k +: NIBBLE_W] = c_nib;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nib_idx   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            sum_q     <= '0;
            carries_q <= '0;
            cout_q    <= 1'b0;
            hcout_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else if (accept) begin
            nib_idx <= '0;
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            carry_q <= sub ? ~cin : cin;
        end else if (state_q == RUN) begin
            sum_q     <= sum_nxt;
            carries_q <= carries_nxt;
            carry_q   <= c_nib[4];
            nib_idx   <= nib_idx + 1'b1;
            if (last_nib) begin
                cout_q  <= carries_nxt[WIDTH-1] ^ sub_q;
                hcout_q <= carries_nxt[3] ^ sub_q;
                zero_q  <= (sum_nxt == '0);
            end
        end
    end

    assign sum     = sum_q;
    assign carries = carries_q;
    assign cout    = cout_q;
    assign hcout   = hcout_q;
    assign zero    = zero_q;

endmodule

// File: tb/tb_sm83_alu_nibble_adder.sv
// Bench for the nibble-serial adder: 8- and 16-bit instances against an arithmetic reference.
module tb_sm83_alu_nibble_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic [15:0] carries;
        logic        cout;
        logic        hcout;
        logic        zero;
    } res_t;

    logic clk;
    logic rst;
    logic sel16;

    logic        st8, cin8, sub8, busy8, done8, cout8, hcout8, zero8;
    logic [7:0]  a8, b8, sum8, car8;
    logic        st16, cin16, sub16, busy16, done16, cout16, hcout16, zero16;
    logic [15:0] a16, b16, sum16, car16;

    logic        obs_busy, obs_done, obs_cout, obs_hcout, obs_zero;
    logic [15:0] obs_sum, obs_car;

    int errors = 0;
    int checks = 0;

    sm83_alu_nibble_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst), .start(st8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .carries(car8),
        .cout(cout8), .hcout(hcout8), .zero(zero8)
    );

    sm83_alu_nibble_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(rst), .start(st16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .busy(busy16), .done(done16), .sum(sum16), .carries(car16),
        .cout(cout16), .hcout(hcout16), .zero(zero16)
    );

    assign obs_busy  = sel16 ? busy16  : busy8;
    assign obs_done  = sel16 ? done16  : done8;
    assign obs_cout  = sel16 ? cout16  : cout8;
    assign obs_hcout = sel16 ? hcout16 : hcout8;
    assign obs_zero  = sel16 ? zero16  : zero8;
    assign obs_sum   = sel16 ? sum16   : {8'h00, sum8};
    assign obs_car   = sel16 ? car16   : {8'h00, car8};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, want finish before timeout");
        $fatal(1);
    end

    // Reference: plain integer add/subtract; carry out of bit i is the carry (or
    // absence of borrow) produced by the low i+1 bits.
    function automatic res_t model(int w, logic [15:0] a, logic [15:0] b, bit cin, bit sub);
        res_t   r;
        longint la, lb, ci, m, d;
        r  = '0;
        la = longint'(a);
        lb = longint'(b);
        ci = cin ? 64'sd1 : 64'sd0;
        for (int i = 0; i < w; i++) begin
            m = 64'sd1 <<< (i + 1);
            if (sub)
                r.carries[i] = ((la % m) - (lb % m) - ci) >= 0;
            else
                r.carries[i] = ((la % m) + (lb % m) + ci) >= m;
        end
        d = sub ? (la - lb - ci) : (la + lb + ci);
        m = 64'sd1 <<< w;
        r.sum   = 16'(d & (m - 1));
        r.cout  = sub ? (d < 0) : (d >= m);
        r.hcout = sub ? (((la % 16) - (lb % 16) - ci) < 0) : (((la % 16) + (lb % 16) + ci) > 15);
        r.zero  = (r.sum == 16'h0000);
        return r;
    endfunction

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input bit cin, input bit sub,
                         input bit st);
        if (sel16) begin
            a16 = a; b16 = b; cin16 = cin; sub16 = sub; st16 = st;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub; st8 = st;
        end
    endtask

    // Start one operation, then check the done timing and the result flags.
    task automatic op(input logic [15:0] a, input logic [15:0] b, input bit cin, input bit sub,
                      input string tag);
        res_t e;
        int   w;
        int   n;
        w = sel16 ? 16 : 8;
        n = w / 4;
        e = model(w, a, b, cin, sub);
        @(negedge clk);
        drive(a, b, cin, sub, 1'b1);
        @(negedge clk);
        drive(a, b, cin, sub, 1'b0);
        for (int i = 1; i <= n + 2; i++) begin
            if (i > 1) @(negedge clk);
            checks++;
            if (obs_done !== (i == n + 1)) begin
                errors++;
                $display("FAIL %s done@%0d: got %b want %b", tag, i, obs_done, (i == n + 1));
            end
            if (i == n + 1) begin
                checks++;
                if ({obs_sum, obs_car, obs_cout, obs_hcout, obs_zero} !== e) begin
                    errors++;
                    $display("FAIL %s result: got sum=%h car=%h c=%b h=%b z=%b want sum=%h car=%h c=%b h=%b z=%b",
                             tag, obs_sum, obs_car, obs_cout, obs_hcout, obs_zero,
                             e.sum, e.carries, e.cout, e.hcout, e.zero);
                end
            end
            if (i == n + 2) begin
                checks++;
                if ({obs_sum, obs_cout, obs_zero} !== {e.sum, e.cout, e.zero}) begin
                    errors++;
                    $display("FAIL %s hold: got sum=%h c=%b z=%b want sum=%h c=%b z=%b",
                             tag, obs_sum, obs_cout, obs_zero, e.sum, e.cout, e.zero);
                end
            end
        end
    endtask

    task automatic test_reset();
        sel16 = 1'b0;
        rst = 1'b1;
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; sub8 = 1'b0; st8 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b1; sub16 = 1'b0; st16 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy8, done8, sum8, car8, cout8, hcout8, zero8} !== 21'h0) begin
            errors++;
            $display("FAIL reset8: got %h want 0", {busy8, done8, sum8, car8, cout8, hcout8, zero8});
        end
        checks++;
        if ({busy16, done16, sum16, car16, cout16, hcout16, zero16} !== 37'h0) begin
            errors++;
            $display("FAIL reset16: got %h want 0",
                     {busy16, done16, sum16, car16, cout16, hcout16, zero16});
        end
        st8 = 1'b0; st16 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy8, done8, busy16, done16} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: got %b want 0000", {busy8, done8, busy16, done16});
        end
    endtask

    task automatic test_directed8();
        sel16 = 1'b0;
        op(16'h0F, 16'h01, 1'b0, 1'b0, "add_0f_01");
        op(16'hFF, 16'h01, 1'b0, 1'b0, "add_ff_01");
        op(16'h10, 16'h01, 1'b0, 1'b1, "sub_10_01");
        op(16'h00, 16'h00, 1'b1, 1'b1, "sub_00_00_c");
        op(16'h7F, 16'h80, 1'b1, 1'b0, "add_7f_80_c");
        op(16'h55, 16'h55, 1'b0, 1'b1, "sub_zero");
    endtask

    task automatic test_ignore_start();
        res_t e;
        sel16 = 1'b0;
        e = model(8, 16'h21, 16'h34, 1'b0, 1'b0);
        @(negedge clk);
        drive(16'h21, 16'h34, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(16'hFF, 16'hFF, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drive(16'h00, 16'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy: got busy=%b done=%b want busy=1 done=0", busy8, done8);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b1 || {8'h00, sum8} !== e.sum || {8'h00, car8} !== e.carries) begin
            errors++;
            $display("FAIL ignore_result: got done=%b sum=%h car=%h want done=1 sum=%h car=%h",
                     done8, sum8, car8, e.sum, e.carries);
        end
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_idle: got busy=%b done=%b want 0 0", busy8, done8);
        end
    endtask

    task automatic test_back_to_back();
        res_t ea, eb;
        bit   seen;
        sel16 = 1'b0;
        ea = model(8, 16'h3C, 16'h0E, 1'b1, 1'b0);
        eb = model(8, 16'h02, 16'h05, 1'b0, 1'b1);
        seen = 1'b0;
        @(negedge clk);
        drive(16'h3C, 16'h0E, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(16'h3C, 16'h0E, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8 && !seen; i++) begin
            if (done8 === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen || {8'h00, sum8} !== ea.sum) begin
            errors++;
            $display("FAIL b2b_first: got seen=%b sum=%h want seen=1 sum=%h", seen, sum8, ea.sum);
        end
        drive(16'h02, 16'h05, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drive(16'h00, 16'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_idle: got busy=%b want 1", busy8);
        end
        for (int j = 2; j <= 3; j++) begin
            @(negedge clk);
            checks++;
            if (done8 !== (j == 3)) begin
                errors++;
                $display("FAIL b2b_done@%0d: got %b want %b", j, done8, (j == 3));
            end
        end
        checks++;
        if ({8'h00, sum8} !== eb.sum || cout8 !== eb.cout || hcout8 !== eb.hcout) begin
            errors++;
            $display("FAIL b2b_second: got sum=%h c=%b h=%b want sum=%h c=%b h=%b",
                     sum8, cout8, hcout8, eb.sum, eb.cout, eb.hcout);
        end
    endtask

    task automatic test_reset_in_run();
        sel16 = 1'b0;
        @(negedge clk);
        drive(16'h9A, 16'h77, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(16'h9A, 16'h77, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy8, done8, sum8, car8, cout8, hcout8, zero8} !== 21'h0) begin
            errors++;
            $display("FAIL abort_clear: got %h want 0", {busy8, done8, sum8, car8, cout8, hcout8, zero8});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet@%0d: got busy=%b done=%b want 0 0", i, busy8, done8);
            end
        end
    endtask

    task automatic test_width16();
        logic [15:0] a, b;
        sel16 = 1'b1;
        op(16'h0FFF, 16'h0001, 1'b0, 1'b0, "w16_add_0fff");
        op(16'h0000, 16'h0001, 1'b0, 1'b1, "w16_sub_under");
        for (int i = 0; i < 25; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            op(a, b, 1'($urandom), 1'($urandom), "w16_rand");
        end
        sel16 = 1'b0;
    endtask

    task automatic test_random8();
        logic [15:0] a, b;
        sel16 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            a = {8'h00, 8'($urandom)};
            b = {8'h00, 8'($urandom)};
            op(a, b, 1'($urandom), 1'($urandom), "w8_rand");
        end
    endtask

    initial begin
        rst = 1'b1;
        sel16 = 1'b0;
        st8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        st16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
        test_reset();
        test_directed8();
        test_ignore_start();
        test_back_to_back();
        test_reset_in_run();
        test_width16();
        test_random8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
